// File: rtl/jk_monitor.sv
// JK flip-flop behaviour monitor: seeds a prediction from the observed flop,
// then checks q/qb against the predicted JK behaviour for CHECK_LEN edges.
module jk_monitor #(
    parameter int CHECK_LEN = 16,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             j,
    input  logic             k,
    input  logic             dut_rst,
    input  logic             q,
    input  logic             qb,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             err,
    output logic             err_sticky,
    output logic [CNT_W-1:0] err_count,
    output logic [15:0]      chk_count
);

    typedef enum logic [1:0] {IDLE, SYNC, CHECK, DONE} state_t;

    localparam logic [15:0]      LEN16   = 16'(CHECK_LEN);
    localparam logic [CNT_W-1:0] ERR_MAX = '1;
    localparam logic [CNT_W-1:0] ERR_ONE = CNT_W'(1);

    state_t            state_reg, state_next;
    logic              exp_q_reg, exp_q_next;
    logic              sticky_next;
    logic              err_next;
    logic [CNT_W-1:0]  err_count_next;
    logic [15:0]       chk_count_next;
    logic              mismatch;

    function automatic logic jk_next(input logic r, input logic jj,
                                     input logic kk, input logic x);
        logic n;
        if (r) begin
            n = 1'b0;
        end else begin
            case ({jj, kk})
                2'b00:   n = x;
                2'b01:   n = 1'b0;
                2'b10:   n = 1'b1;
                default: n = ~x;
            endcase
        end
        return n;
    endfunction

    always_comb begin
        state_next     = state_reg;
        exp_q_next     = exp_q_reg;
        sticky_next    = err_sticky;
        err_next       = 1'b0;
        err_count_next = err_count;
        chk_count_next = chk_count;
        // Case equality so X/Z on the observed outputs is flagged in simulation.
        mismatch       = (q !== exp_q_reg) || (qb !== ~q);

        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    state_next     = SYNC;
                    sticky_next    = 1'b0;
                    err_count_next = '0;
                    chk_count_next = '0;
                end
            end
            SYNC: begin
                exp_q_next = jk_next(dut_rst, j, k, q);
                state_next = CHECK;
            end
            CHECK: begin
                // Prediction runs from our own expectation so one fault is never hidden.
                exp_q_next     = jk_next(dut_rst, j, k, exp_q_reg);
                chk_count_next = chk_count + 16'd1;
                if (mismatch) begin
                    err_next    = 1'b1;
                    sticky_next = 1'b1;
                    if (err_count != ERR_MAX)
                        err_count_next = err_count + ERR_ONE;
                end
                if (chk_count_next == LEN16)
                    state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= IDLE;
            exp_q_reg  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err        <= 1'b0;
            err_sticky <= 1'b0;
            err_count  <= '0;
            chk_count  <= '0;
        end else begin
            state_reg  <= state_next;
            exp_q_reg  <= exp_q_next;
            busy       <= (state_next == SYNC) || (state_next == CHECK);
            done       <= (state_next == DONE);
            pass       <= (state_next == DONE) && !sticky_next;
            err        <= err_next;
            err_sticky <= sticky_next;
            err_count  <= err_count_next;
            chk_count  <= chk_count_next;
        end
    end

endmodule

// File: tb/tb_jk_monitor.sv
// Randomised self-checking bench for jk_monitor: two instances (different run
// length / counter width) watch an emulated JK flop with injectable faults.
`timescale 1ns/1ps
module tb_jk_monitor;

    localparam int LEN_A = 5;
    localparam int CW_A  = 8;
    localparam int LEN_B = 10;
    localparam int CW_B  = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0, j = 1'b0, k = 1'b0, dut_rst = 1'b0;
    logic fq = 1'b0, hold = 1'b0, invert = 1'b0, qb_stuck = 1'b0;
    logic q, qb;

    logic busy_a, done_a, pass_a, err_a, stk_a;
    logic [CW_A-1:0] ec_a;
    logic [15:0] cc_a;
    logic busy_b, done_b, pass_b, err_b, stk_b;
    logic [CW_B-1:0] ec_b;
    logic [15:0] cc_b;

    int n_cmp = 0;
    int n_bad = 0;
    int pulses_a = 0;
    int pulses_b = 0;

    typedef struct {
        int   ph;     // 0 idle, 1 seeding, 2 comparing, 3 finished
        logic exq;
        int   nchk;
        int   nerr;
        logic stk;
        logic errp;
    } mstate_t;

    mstate_t mst [2];

    assign q  = fq ^ invert;
    assign qb = qb_stuck ? q : ~q;

    jk_monitor #(.CHECK_LEN(LEN_A), .CNT_W(CW_A)) u_a (
        .clk(clk), .rst(rst), .start(start), .j(j), .k(k), .dut_rst(dut_rst),
        .q(q), .qb(qb), .busy(busy_a), .done(done_a), .pass(pass_a), .err(err_a),
        .err_sticky(stk_a), .err_count(ec_a), .chk_count(cc_a));

    jk_monitor #(.CHECK_LEN(LEN_B), .CNT_W(CW_B)) u_b (
        .clk(clk), .rst(rst), .start(start), .j(j), .k(k), .dut_rst(dut_rst),
        .q(q), .qb(qb), .busy(busy_b), .done(done_b), .pass(pass_b), .err(err_b),
        .err_sticky(stk_b), .err_count(ec_b), .chk_count(cc_b));

    always #50 clk = ~clk;

    function automatic logic nxt(input logic r, input logic jj, input logic kk, input logic x);
        if (r) return 1'b0;
        if (!jj && !kk) return x;
        if (!jj && kk) return 1'b0;
        if (jj && !kk) return 1'b1;
        return ~x;
    endfunction

    function automatic mstate_t model_zero();
        mstate_t z;
        z.ph = 0; z.exq = 1'b0; z.nchk = 0; z.nerr = 0; z.stk = 1'b0; z.errp = 1'b0;
        return z;
    endfunction

    function automatic mstate_t model_step(input mstate_t m, input int len, input int maxc,
                                           input logic s, input logic r, input logic jj,
                                           input logic kk, input logic qq, input logic qbb);
        mstate_t n = m;
        n.errp = 1'b0;
        if (m.ph == 0 || m.ph == 3) begin
            if (s) begin
                n.ph = 1; n.stk = 1'b0; n.nerr = 0; n.nchk = 0;
            end
        end else if (m.ph == 1) begin
            n.exq = nxt(r, jj, kk, qq);
            n.ph  = 2;
        end else begin
            if ((qq !== m.exq) || (qbb !== ~qq)) begin
                n.errp = 1'b1;
                n.stk  = 1'b1;
                if (n.nerr < maxc) n.nerr = n.nerr + 1;
            end
            n.exq  = nxt(r, jj, kk, m.exq);
            n.nchk = m.nchk + 1;
            if (n.nchk == len) n.ph = 3;
        end
        return n;
    endfunction

    // Emulated observed flop (with hold fault), updated after the monitors sample it.
    initial forever begin
        @(posedge clk);
        fq <= hold ? fq : nxt(dut_rst, j, k, fq);
    end

    initial begin
        mst[0] = model_zero();
        mst[1] = model_zero();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                mst[0] = model_zero();
                mst[1] = model_zero();
            end else begin
                mst[0] = model_step(mst[0], LEN_A, (1 << CW_A) - 1, start, dut_rst, j, k, q, qb);
                mst[1] = model_step(mst[1], LEN_B, (1 << CW_B) - 1, start, dut_rst, j, k, q, qb);
            end
        end
    end

    task automatic chk(input string name, input int act, input int expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    task automatic cmp_inst(input string tag, input mstate_t m, input int b, input int d,
                            input int p, input int e, input int s, input int ec, input int cc);
        chk({tag, " busy"}, b, (m.ph == 1 || m.ph == 2) ? 1 : 0);
        chk({tag, " done"}, d, (m.ph == 3) ? 1 : 0);
        chk({tag, " pass"}, p, (m.ph == 3 && !m.stk) ? 1 : 0);
        chk({tag, " err"}, e, int'(m.errp));
        chk({tag, " err_sticky"}, s, int'(m.stk));
        chk({tag, " err_count"}, ec, m.nerr);
        chk({tag, " chk_count"}, cc, m.nchk);
    endtask

    // Compare process: every falling edge, both monitors against the model.
    initial forever begin
        @(negedge clk);
        cmp_inst("A", mst[0], int'(busy_a), int'(done_a), int'(pass_a), int'(err_a),
                 int'(stk_a), int'(ec_a), int'(cc_a));
        cmp_inst("B", mst[1], int'(busy_b), int'(done_b), int'(pass_b), int'(err_b),
                 int'(stk_b), int'(ec_b), int'(cc_b));
        if (err_a) pulses_a++;
        if (err_b) pulses_b++;
    end

    task automatic drive(input logic s, input logic r, input logic jj, input logic kk);
        start = s; dut_rst = r; j = jj; k = kk;
        @(negedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic drive_rand(input logic s);
        drive(s, ($urandom_range(0, 7) == 0), 1'($urandom), 1'($urandom));
    endtask

    int base_a, base_b;
    logic pr [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic pj [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic pk [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        @(negedge clk);
        #1;
        // Reset state
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset busy", int'(busy_a), 0);
        chk("reset err_count", int'(ec_a), 0);
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk("idle after release busy", int'(busy_a), 0);

        // Correct flop with the fixed reset/hold/clear/set/toggle pattern
        for (int c = 0; c < 10; c++) drive(1'b0, pr[c % 5], pj[c % 5], pk[c % 5]);
        drive(1'b1, pr[0], pj[0], pk[0]);
        for (int c = 1; c < 13; c++) drive(1'b0, pr[c % 5], pj[c % 5], pk[c % 5]);
        chk("good A done", int'(done_a), 1);
        chk("good A pass", int'(pass_a), 1);
        chk("good A err_count", int'(ec_a), 0);
        chk("good A chk_count", int'(cc_a), 5);
        chk("good B chk_count", int'(cc_b), 10);
        chk("good B pass", int'(pass_b), 1);

        // Toggle fault: holds on the 1st and 3rd compare edges
        base_a = pulses_a; base_b = pulses_b;
        drive(1'b1, 1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        for (int t = 0; t < 11; t++) begin
            hold = (t == 0 || t == 2);
            drive(1'b0, 1'b0, 1'b1, 1'b1);
            hold = 1'b0;
        end
        chk("toggle A pulses", pulses_a - base_a, 2);
        chk("toggle A err_count", int'(ec_a), 2);
        chk("toggle A pass", int'(pass_a), 0);
        chk("toggle A err_sticky", int'(stk_a), 1);
        chk("toggle B pulses", pulses_b - base_b, 2);

        // qb equal to q for one cycle
        base_a = pulses_a;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive_rand(1'b0);
        for (int t = 0; t < 11; t++) begin
            qb_stuck = (t == 2);
            drive(1'b0, 1'b0, 1'($urandom), 1'($urandom));
            qb_stuck = 1'b0;
        end
        chk("qb A pulses", pulses_a - base_a, 1);
        chk("qb A err_count", int'(ec_a), 1);
        chk("qb B err_count", int'(ec_b), 1);

        // Constantly inverted q: B's 2-bit counter saturates
        invert = 1'b1;
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        base_a = pulses_a; base_b = pulses_b;
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        for (int t = 0; t < 12; t++) drive(1'b0, 1'b0, 1'b1, 1'b0);
        invert = 1'b0;
        chk("invert B err_count", int'(ec_b), 3);
        chk("invert B pulses", pulses_b - base_b, 10);
        chk("invert A err_count", int'(ec_a), 5);

        // Start in DONE clears; start mid-run and on the final edge is ignored
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        chk("restart A busy", int'(busy_a), 1);
        chk("restart A err_sticky", int'(stk_a), 0);
        chk("restart B err_count", int'(ec_b), 0);
        drive_rand(1'b0);
        for (int t = 0; t < 11; t++) begin
            drive_rand(t == 1 || t == 4);
            if (t == 4) begin
                chk("final-edge start A done", int'(done_a), 1);
                chk("final-edge start A chk_count", int'(cc_a), 5);
            end
        end
        chk("ignored start B chk_count", int'(cc_b), 10);
        drive_rand(1'b1);
        chk("done start A chk_count", int'(cc_a), 0);
        chk("done start B busy", int'(busy_b), 1);
        for (int t = 0; t < 12; t++) drive_rand(1'b0);

        // Reset in the middle of a run that already has errors
        drive(1'b1, 1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        for (int t = 0; t < 3; t++) begin
            hold = (t == 0);
            drive(1'b0, 1'b0, 1'b1, 1'b1);
            hold = 1'b0;
        end
        chk("pre-reset A chk_count", int'(cc_a), 3);
        rst = 1'b0;
        #1;
        chk("async reset A busy", int'(busy_a), 0);
        chk("async reset A err_sticky", int'(stk_a), 0);
        chk("async reset A err_count", int'(ec_a), 0);
        chk("async reset A chk_count", int'(cc_a), 0);
        chk("async reset A err", int'(err_a), 0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        for (int t = 0; t < 3; t++) drive_rand(1'b0);
        chk("post-reset A idle busy", int'(busy_a), 0);
        chk("post-reset A done", int'(done_a), 0);
        drive_rand(1'b1);
        chk("fresh run A busy", int'(busy_a), 1);
        chk("fresh run A chk_count", int'(cc_a), 0);
        for (int t = 0; t < 12; t++) drive_rand(1'b0);

        // Random traffic with sparse faults and occasional resets
        for (int c = 0; c < 3000; c++) begin
            hold     = ($urandom_range(0, 15) == 0);
            qb_stuck = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 63) == 0) invert = ~invert;
            rst = ($urandom_range(0, 199) != 0);
            drive_rand($urandom_range(0, 7) == 0);
        end
        hold = 1'b0; qb_stuck = 1'b0; invert = 1'b0; rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
